// File: rtl/lot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lot_pkg
//  Description : Types and constants shared by the parking-lot gate logic.
//                COUNT_W  - width of the occupancy count (fits 0..99).
//                state_e  - gate arbiter FSM states.
//                lane_e   - lane identifier, used for the last-grant pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
package lot_pkg;

    localparam int COUNT_W = 7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2,
        SETTLE   = 2'd3
    } state_e;

    typedef enum logic [0:0] {
        LANE_IN  = 1'b0,
        LANE_OUT = 1'b1
    } lane_e;

endpackage : lot_pkg
`default_nettype wire

// File: rtl/gate_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : gate_arbiter_if
//  Description : Lane/gate signal bundle between the lot controller and the
//                gate arbiter.
//                req_in / req_out  : lane car-present levels
//                pass              : car cleared the gate
//                grant_in/grant_out: lane owning the gate
//                gate_open         : barrier raised
//                count / full      : occupancy and lot-full flag
//                err               : one-cycle error pulse
//                Modports: master (controller side), slave (arbiter side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface gate_arbiter_if;
    import lot_pkg::*;

    logic               req_in;
    logic               req_out;
    logic               pass;
    logic               grant_in;
    logic               grant_out;
    logic               gate_open;
    logic [COUNT_W-1:0] count;
    logic               full;
    logic               err;

    modport master (
        output req_in, req_out, pass,
        input  grant_in, grant_out, gate_open, count, full, err
    );

    modport slave (
        input  req_in, req_out, pass,
        output grant_in, grant_out, gate_open, count, full, err
    );

endinterface : gate_arbiter_if
`default_nettype wire

// File: rtl/gate_timer.sv
`default_nettype none
// ============================================================================
//  Module      : gate_timer
//  Description : Gate-open window counter. Held at zero while clear_i is
//                high; otherwise counts one per cycle and raises expire_o
//                during the CYCLES-th counted cycle (count == CYCLES-1).
//  Ports       : clk      - system clock
//                rst_n    - asynchronous active-low reset
//                clear_i  - hold the counter at zero
//                expire_o - window exhausted (combinational from count)
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_timer #(
    parameter int CYCLES = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clear_i,
    output logic      expire_o
);

    localparam int          W      = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST_C = W'(CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expire_o = !clear_i && (cnt_q == LAST_C);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (!expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : gate_timer
`default_nettype wire

// File: rtl/gate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gate_arbiter
//  Description : Shares one barrier gate between the entry and exit lanes
//                and owns the lot occupancy count. One lane is granted at a
//                time (round-robin on ties, entry blocked while full); the
//                gate stays open until pass (or timeout), then closes for
//                one SETTLE cycle before the next arbitration.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - gate_arbiter_if.slave (requests, pass, grants,
//                        gate_open, count, full, err)
//  Parameters  : CAPACITY    - maximum occupancy (<= 99)
//                OPEN_CYCLES - gate-open window before timeout (>= 2)
//  Build macro : GATE_TIMEOUT_EN - when defined, an open gate without pass
//                is aborted after OPEN_CYCLES cycles with an err pulse;
//                otherwise the gate waits for pass indefinitely.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_arbiter
    import lot_pkg::*;
#(
    parameter int CAPACITY    = 99,
    parameter int OPEN_CYCLES = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    gate_arbiter_if.slave  bus
);

    // Elaboration-time parameter sanity checks.
    if (CAPACITY < 0 || CAPACITY > 99 || CAPACITY >= (1 << COUNT_W)) begin : g_bad_capacity
        $error("gate_arbiter: CAPACITY out of range");
    end
    if (OPEN_CYCLES < 2) begin : g_bad_open_cycles
        $error("gate_arbiter: OPEN_CYCLES must be at least 2");
    end

    localparam logic [COUNT_W-1:0] CAP_C = COUNT_W'(CAPACITY);

    state_e             state_q, state_d;
    lane_e              last_q,  last_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               err_q,   err_d;

    logic               open_w;
    logic               full_w;
    logic               timeout_w;

    assign open_w = (state_q == OPEN_IN) || (state_q == OPEN_OUT);
    assign full_w = (count_q == CAP_C);

`ifdef GATE_TIMEOUT_EN
    // Held clear outside OPEN_x, so it restarts from zero on every grant.
    gate_timer #(
        .CYCLES (OPEN_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (!open_w),
        .expire_o (timeout_w)
    );
`else
    assign timeout_w = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state, pointer, occupancy and error logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        count_d = count_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Entry is only eligible while the lot has room.
                if (bus.req_in && !full_w && bus.req_out) begin
                    state_d = (last_q == LANE_OUT) ? OPEN_IN : OPEN_OUT;
                end else if (bus.req_in && !full_w) begin
                    state_d = OPEN_IN;
                end else if (bus.req_out) begin
                    state_d = OPEN_OUT;
                end
            end

            OPEN_IN: begin
                // pass takes priority over a coincident timeout.
                if (bus.pass) begin
                    state_d = SETTLE;
                    last_d  = LANE_IN;
                    if (count_q != CAP_C) begin
                        count_d = count_q + 1'b1;
                    end
                end else if (timeout_w) begin
                    state_d = SETTLE;
                    last_d  = LANE_IN;
                    err_d   = 1'b1;
                end
            end

            OPEN_OUT: begin
                if (bus.pass) begin
                    state_d = SETTLE;
                    last_d  = LANE_OUT;
                    if (count_q == '0) begin
                        // Car left an already-empty lot: flag it, keep zero.
                        err_d = 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end else if (timeout_w) begin
                    state_d = SETTLE;
                    last_d  = LANE_OUT;
                    err_d   = 1'b1;
                end
            end

            SETTLE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= LANE_OUT;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    assign bus.grant_in  = (state_q == OPEN_IN);
    assign bus.grant_out = (state_q == OPEN_OUT);
    assign bus.gate_open = open_w;
    assign bus.count     = count_q;
    assign bus.full      = full_w;
    assign bus.err       = err_q;

endmodule : gate_arbiter
`default_nettype wire

// File: tb/tb_gate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_arbiter
//  Description : Directed self-checking bench for gate_arbiter, built with
//                CAPACITY=7 so the occupancy values 5, 6, 7 and the full
//                condition are all reachable. Timeout behaviour follows
//                GATE_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_arbiter;
    import lot_pkg::*;

    localparam int CAP  = 7;
    localparam int OPEN = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    gate_arbiter_if u_if ();

    gate_arbiter #(
        .CAPACITY    (CAP),
        .OPEN_CYCLES (OPEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Complete one entry (IDLE start): grant, pass, back to IDLE.
    task automatic do_entry();
        u_if.req_in = 1'b1;
        tick();
        u_if.req_in = 1'b0;
        u_if.pass   = 1'b1;
        tick();
        u_if.pass   = 1'b0;
        tick();
    endtask

    // Complete one exit (IDLE start).
    task automatic do_exit();
        u_if.req_out = 1'b1;
        tick();
        u_if.req_out = 1'b0;
        u_if.pass    = 1'b1;
        tick();
        u_if.pass    = 1'b0;
        tick();
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        u_if.req_in  = 1'b0;
        u_if.req_out = 1'b0;
        u_if.pass    = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_grant_in",  int'(u_if.grant_in),  0);
        chk("rst_grant_out", int'(u_if.grant_out), 0);
        chk("rst_gate_open", int'(u_if.gate_open), 0);
        chk("rst_count",     int'(u_if.count),     0);
        chk("rst_full",      int'(u_if.full),      0);
        chk("rst_err",       int'(u_if.err),       0);

        // ---------------- single entry ----------------
        u_if.req_in = 1'b1;
        tick();
        chk("se_grant_in", int'(u_if.grant_in),  1);
        chk("se_gate",     int'(u_if.gate_open), 1);
        tick();
        tick();
        chk("se_wait_gate", int'(u_if.gate_open), 1);
        u_if.pass = 1'b1;
        tick();                                  // edge M
        u_if.pass = 1'b0;
        chk("se_count", int'(u_if.count),     1);
        chk("se_gate0", int'(u_if.gate_open), 0);
        tick();                                  // edge M+1: IDLE
        chk("se_idle_grant", int'(u_if.grant_in), 0);
        tick();                                  // edge M+2: re-grant
        chk("se_regrant", int'(u_if.grant_in), 1);
        u_if.req_in = 1'b0;
        u_if.pass   = 1'b1;
        tick();
        u_if.pass   = 1'b0;
        chk("se_count2", int'(u_if.count), 2);
        tick();

        // pass in IDLE is ignored
        u_if.pass = 1'b1;
        tick();
        u_if.pass = 1'b0;
        chk("idle_pass_count", int'(u_if.count), 2);
        chk("idle_pass_err",   int'(u_if.err),   0);

        // count -> 6 via entries, then one exit -> 5 with pointer = out
        do_entry();
        do_entry();
        do_entry();
        do_entry();
        chk("pre_tie_count6", int'(u_if.count), 6);
        do_exit();
        chk("pre_tie_count5", int'(u_if.count), 5);

        // ---------------- tie fairness ----------------
        u_if.req_in  = 1'b1;
        u_if.req_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tie_grant_in",  int'(u_if.grant_in),  (i % 2 == 0) ? 1 : 0);
            chk("tie_grant_out", int'(u_if.grant_out), (i % 2 == 0) ? 0 : 1);
            u_if.pass = 1'b1;
            tick();
            u_if.pass = 1'b0;
            chk("tie_count", int'(u_if.count), (i % 2 == 0) ? 6 : 5);
            tick();
        end
        u_if.req_in  = 1'b0;
        u_if.req_out = 1'b0;

        // ---------------- full lot ----------------
        do_entry();
        do_entry();
        chk("full_count", int'(u_if.count), 7);
        chk("full_flag",  int'(u_if.full),  1);
        u_if.req_in = 1'b1;
        tick();
        tick();
        chk("full_no_grant", int'(u_if.gate_open), 0);
        u_if.req_out = 1'b1;
        tick();
        chk("full_grant_out", int'(u_if.grant_out), 1);
        u_if.pass = 1'b1;
        tick();
        u_if.pass    = 1'b0;
        u_if.req_out = 1'b0;
        chk("full_exit_count", int'(u_if.count), 6);
        chk("full_exit_flag",  int'(u_if.full),  0);
        tick();
        tick();
        chk("full_then_in", int'(u_if.grant_in), 1);
        u_if.req_in = 1'b0;
        u_if.pass   = 1'b1;
        tick();
        u_if.pass   = 1'b0;
        chk("refill_count", int'(u_if.count), 7);
        tick();

        // ---------------- async reset mid OPEN_OUT ----------------
        u_if.req_out = 1'b1;
        tick();
        chk("ar_grant_out", int'(u_if.grant_out), 1);
        chk("ar_count7",    int'(u_if.count),     7);
        #2;
        rst_n = 1'b0;                            // well away from any edge
        #1;
        chk("ar_gate",  int'(u_if.gate_open), 0);
        chk("ar_count", int'(u_if.count),     0);
        u_if.req_out = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // ---------------- empty exit ----------------
        u_if.req_out = 1'b1;
        tick();
        chk("ee_grant_out", int'(u_if.grant_out), 1);
        u_if.req_out = 1'b0;
        u_if.pass    = 1'b1;
        tick();
        u_if.pass    = 1'b0;
        chk("ee_count", int'(u_if.count), 0);
        chk("ee_err",   int'(u_if.err),   1);
        tick();
        chk("ee_err_low", int'(u_if.err), 0);

        // ---------------- timeout / no-timeout ----------------
        u_if.req_in = 1'b1;
        tick();
        chk("to_grant_in", int'(u_if.grant_in), 1);
        u_if.req_in = 1'b0;
`ifdef GATE_TIMEOUT_EN
        repeat (OPEN - 1) tick();
        chk("to_still_open", int'(u_if.gate_open), 1);
        chk("to_no_err_yet", int'(u_if.err),       0);
        tick();
        chk("to_gate_closed", int'(u_if.gate_open), 0);
        chk("to_err",         int'(u_if.err),       1);
        chk("to_count",       int'(u_if.count),     0);
`else
        repeat (50) tick();
        chk("nto_still_open", int'(u_if.gate_open), 1);
        chk("nto_no_err",     int'(u_if.err),       0);
        u_if.pass = 1'b1;
        tick();
        u_if.pass = 1'b0;
        chk("nto_count", int'(u_if.count), 1);
`endif
        // Last grant was the entry lane, so the next tie goes out.
        u_if.req_in  = 1'b1;
        u_if.req_out = 1'b1;
        tick();
        chk("post_err_low", int'(u_if.err), 0);
        tick();
        chk("post_tie_out", int'(u_if.grant_out), 1);
        u_if.req_in  = 1'b0;
        u_if.req_out = 1'b0;
        u_if.pass    = 1'b1;
        tick();
        u_if.pass    = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_gate_arbiter
`default_nettype wire
